// File: rtl/rx_deframer_pkg.sv
// rtl/rx_deframer_pkg.sv - shared types and constants for the receive deframer
// Contents: FSM state enum, default sync word, keystream slice bounds
// (the slice bounds are shared with the transmit encryptor).
package rx_deframer_pkg;

    typedef enum logic [2:0] {
        ST_HUNT,
        ST_HDR2,
        ST_SEED,
        ST_LEN,
        ST_PAY_HI,
        ST_PAY_LO,
        ST_CSUM
    } rx_state_t;

    localparam logic [15:0] SYNC_WORD_DEFAULT = 16'hCAFE;
    localparam int          KEY_SLICE_MSB     = 27;
    localparam int          KEY_SLICE_LSB     = 12;

endpackage

// File: rtl/rx_deframer_fifo.sv
// rtl/rx_deframer_fifo.sv - sample_fifo: first-word fall-through sample FIFO
// Ports: clk, rst (sync, active-high), wr_en/wr_data (write side),
//        rd_en (pop, honoured only when not empty), rd_data (head word),
//        full, empty.
// A write while full is accepted only when a pop happens in the same cycle.
module sample_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int          AW      = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_rd;
    logic             do_wr;

    // Extra pointer MSB distinguishes full from empty when indices match.
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_rd   = rd_en && !empty;
    assign do_wr   = wr_en && (!full || do_rd);
    assign rd_data = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr[AW-1:0]] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_wr) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (do_rd) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
        end
    end

endmodule

// File: rtl/rx_deframer.sv
// rtl/rx_deframer.sv - packet deframer, keystream decryptor and sample queue
// Ports: clk, rst (sync, active-high), rx_enable, spi_rx_data/spi_rx_done
//        (byte input), key_in (keystream), sync_en/sync_state_out (seed load),
//        next_key_en (keystream advance), dac_data_out/dac_data_valid/dac_ready
//        (sample output), pkt_ok/pkt_err (packet status), overflow_cnt.
// Optional feature: RX_CHECKSUM_EN adds a trailing XOR checksum byte.
module rx_deframer
    import rx_deframer_pkg::*;
#(
    parameter int          FIFO_DEPTH     = 16,
    parameter int          TIMEOUT_CYCLES = 4096,
    parameter logic [15:0] SYNC_WORD      = SYNC_WORD_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rx_enable,
    input  logic [7:0]  spi_rx_data,
    input  logic        spi_rx_done,
    input  logic [31:0] key_in,
    output logic        sync_en,
    output logic [31:0] sync_state_out,
    output logic        next_key_en,
    output logic [15:0] dac_data_out,
    output logic        dac_data_valid,
    input  logic        dac_ready,
    output logic        pkt_ok,
    output logic        pkt_err,
    output logic [15:0] overflow_cnt
);

    localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;

    rx_state_t   state;
    rx_state_t   state_nxt;
    logic [7:0]  hi_byte;
    logic [7:0]  word_cnt;
    logic [1:0]  seed_cnt;
    logic [TW-1:0] idle_cnt;
    logic        timeout;
    logic        ok_c;
    logic        err_c;
    logic        key_adv;
    logic        seed_done;
    logic        fifo_wr;
    logic        fifo_full;
    logic        fifo_empty;
    logic        fifo_pop;
    logic [15:0] sample;
`ifdef RX_CHECKSUM_EN
    logic [7:0]  csum_acc;
`endif

    // The keystream slice is taken before next_key_en advances the generator.
    assign sample  = {hi_byte, spi_rx_data} ^ key_in[KEY_SLICE_MSB:KEY_SLICE_LSB];
    assign timeout = (state != ST_HUNT) && !spi_rx_done && (idle_cnt == TW'(TIMEOUT_CYCLES - 1));

    always_comb begin
        state_nxt = state;
        ok_c      = 1'b0;
        err_c     = 1'b0;
        key_adv   = 1'b0;
        seed_done = 1'b0;
        if (!rx_enable) begin
            state_nxt = ST_HUNT;
            err_c     = (state != ST_HUNT);
        end else if (spi_rx_done) begin
            case (state)
                ST_HUNT: begin
                    if (spi_rx_data == SYNC_WORD[15:8]) state_nxt = ST_HDR2;
                end
                ST_HDR2: begin
                    if (spi_rx_data == SYNC_WORD[7:0])       state_nxt = ST_SEED;
                    else if (spi_rx_data == SYNC_WORD[15:8]) state_nxt = ST_HDR2;
                    else                                     state_nxt = ST_HUNT;
                end
                ST_SEED: begin
                    if (seed_cnt == 2'd3) begin
                        seed_done = 1'b1;
                        state_nxt = ST_LEN;
                    end
                end
                ST_LEN: begin
                    if (spi_rx_data == 8'd0) begin
                        ok_c      = 1'b1;
                        state_nxt = ST_HUNT;
                    end else begin
                        state_nxt = ST_PAY_HI;
                    end
                end
                ST_PAY_HI: state_nxt = ST_PAY_LO;
                ST_PAY_LO: begin
                    key_adv = 1'b1;
                    if (word_cnt == 8'd1) begin
`ifdef RX_CHECKSUM_EN
                        state_nxt = ST_CSUM;
`else
                        ok_c      = 1'b1;
                        state_nxt = ST_HUNT;
`endif
                    end else begin
                        state_nxt = ST_PAY_HI;
                    end
                end
`ifdef RX_CHECKSUM_EN
                ST_CSUM: begin
                    ok_c      = (spi_rx_data == csum_acc);
                    err_c     = (spi_rx_data != csum_acc);
                    state_nxt = ST_HUNT;
                end
`endif
                default: state_nxt = ST_HUNT;
            endcase
        end else if (timeout) begin
            err_c     = 1'b1;
            state_nxt = ST_HUNT;
        end
    end

    // Mealy pulses are masked during reset so a mid-packet reset stays silent.
    assign pkt_ok      = ok_c && !rst;
    assign pkt_err     = err_c && !rst;
    assign next_key_en = key_adv && !rst;
    assign fifo_wr     = key_adv && !rst;
    assign fifo_pop    = dac_data_valid && dac_ready;
    assign dac_data_valid = !fifo_empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= ST_HUNT;
            sync_en        <= 1'b0;
            sync_state_out <= '0;
            hi_byte        <= '0;
            word_cnt       <= '0;
            seed_cnt       <= '0;
            idle_cnt       <= '0;
            overflow_cnt   <= '0;
`ifdef RX_CHECKSUM_EN
            csum_acc       <= '0;
`endif
        end else begin
            state   <= state_nxt;
            sync_en <= seed_done;

            if (spi_rx_done || state == ST_HUNT) idle_cnt <= '0;
            else                                 idle_cnt <= idle_cnt + TW'(1);

            if (state != ST_SEED) seed_cnt <= '0;

            if (rx_enable && spi_rx_done) begin
                case (state)
                    ST_SEED: begin
                        sync_state_out <= {sync_state_out[23:0], spi_rx_data};
                        seed_cnt       <= seed_cnt + 2'd1;
                    end
                    ST_LEN: begin
                        word_cnt <= spi_rx_data;
`ifdef RX_CHECKSUM_EN
                        csum_acc <= '0;
`endif
                    end
                    ST_PAY_HI: begin
                        hi_byte <= spi_rx_data;
`ifdef RX_CHECKSUM_EN
                        csum_acc <= csum_acc ^ spi_rx_data;
`endif
                    end
                    ST_PAY_LO: begin
                        word_cnt <= word_cnt - 8'd1;
`ifdef RX_CHECKSUM_EN
                        csum_acc <= csum_acc ^ spi_rx_data;
`endif
                    end
                    default: ;
                endcase
            end

            if (fifo_wr && fifo_full && !fifo_pop && overflow_cnt != 16'hFFFF) begin
                overflow_cnt <= overflow_cnt + 16'd1;
            end
        end
    end

    sample_fifo #(
        .WIDTH (16),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (fifo_wr),
        .wr_data (sample),
        .rd_en   (fifo_pop),
        .rd_data (dac_data_out),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

endmodule
